// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and the
// bus request decode used by the top level.
package data_mem_responder_pkg;

  localparam int unsigned RESP_STATE_COUNT = 1;
  localparam logic [RESP_STATE_COUNT-1:0] RESP_STATE_INIT  = 1'b0;
  localparam logic [RESP_STATE_COUNT-1:0] RESP_STATE_READY = 1'b1;

  typedef struct packed {
    logic rd;
    logic wr;
    logic bad;
  } bus_req_t;

  // Qualifies a bus cycle that already hits the window; 'bad' is the sticky-error cause.
  function automatic bus_req_t decode_req(input logic cs, input logic we, input logic oe,
                                          input logic in_win, input logic ready);
    bus_req_t r;
    r.rd  = ready & cs & in_win & oe & ~we;
    r.wr  = ready & cs & in_win & we & ~oe;
    r.bad = cs & in_win & ((we & oe) | (~ready & (we | oe)));
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the control unit (master) and the RAM responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] bus_addr;
  wire  [DATA_WIDTH-1:0] bus_data;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (output bus_addr, output mem_cs, output mem_we, output mem_oe,
                  inout bus_data);
  modport slave  (input bus_addr, input mem_cs, input mem_we, input mem_oe,
                  inout bus_data);

endinterface

// File: rtl/data_mem_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module data_mem_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// RAM responder on the control unit's data-memory bus: clears the array after
// reset, then serves zero-latency reads and single-edge writes in its window.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 'h40,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 'hBF
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 init_busy,
  output logic                 access_error
);

  localparam int unsigned DEPTH = 32'(MEM_STOP_ADDR - MEM_START_ADDR) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [RESP_STATE_COUNT-1:0] state;
  logic [IDX_W-1:0]            clr_cnt;
  logic [IDX_W-1:0]            bus_idx;
  logic                        in_window;
  logic                        ready;
  bus_req_t                    req;

  logic                  arr_we;
  logic [IDX_W-1:0]      arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Full-width compare so any set upper address bit falls outside the window.
  assign in_window = (bus.bus_addr >= MEM_START_ADDR) && (bus.bus_addr <= MEM_STOP_ADDR);
  assign bus_idx   = IDX_W'(bus.bus_addr - MEM_START_ADDR);
  assign ready     = (state == RESP_STATE_READY);
  assign req       = decode_req(bus.mem_cs, bus.mem_we, bus.mem_oe, in_window, ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RESP_STATE_INIT;
      clr_cnt <= '0;
    end else if (state == RESP_STATE_INIT) begin
      clr_cnt <= clr_cnt + IDX_W'(1);
      if (clr_cnt == IDX_W'(DEPTH - 1)) begin
        state <= RESP_STATE_READY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      access_error <= 1'b0;
    end else if (req.bad) begin
      access_error <= 1'b1;
    end
  end

  assign init_busy = (state == RESP_STATE_INIT);

  // The clear owns the write port for the whole INIT phase; bus writes only once READY.
  always_comb begin
    arr_we    = req.wr;
    arr_waddr = bus_idx;
    arr_wdata = bus.bus_data;
    if (!ready) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt;
      arr_wdata = '0;
    end
  end

  data_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (bus_idx),
    .rdata (arr_rdata)
  );

  assign bus.bus_data = (req.rd && reset) ? arr_rdata : 'z;

endmodule
